// File: rtl/pc_fetch_stage.sv
// Fetch stage: PC register, next-PC select (pc+4/branch/jump/jr) and IF/ID capture; `FETCH_IRQ_EN adds irq/epc.
// Latency: imem_addr is combinational from pc; the fetched instruction lands in IF/ID on the next edge.
// Backpressure: stall holds pc and IF/ID indefinitely without loss; flush clears IF/ID and wins over stall.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  pc_src,
    input  logic [15:0] branch_offset,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    input  logic [31:0] imem_instr,
`ifdef FETCH_IRQ_EN
    input  logic        irq,
    output logic [31:0] epc,
`endif
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;
    logic [31:0] jr_tgt;
    logic [31:0] next_pc;
    logic        irq_take;
    logic        unused_jr_low;
    if_id_t      if_id_q;

`ifdef FETCH_IRQ_EN
    assign irq_take = irq & ~stall;
`else
    assign irq_take = 1'b0;
`endif

    assign imem_addr      = pc;
    assign pc_plus4       = pc + 32'd4;
    assign if_id_instr    = if_id_q.instr;
    assign if_id_pc_plus4 = if_id_q.pc_plus4;
    assign if_id_valid    = if_id_q.valid;

    // Redirect targets are resolved in ID, so they are relative to the instruction now in IF/ID.
    assign branch_tgt    = if_id_q.pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign jump_tgt      = {if_id_q.pc_plus4[31:28], jump_index, 2'b00};
    assign jr_tgt        = {jr_target[31:2], 2'b00};
    assign unused_jr_low = &{1'b0, jr_target[1:0]};

    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            2'b01:   next_pc = branch_tgt;
            2'b10:   next_pc = jump_tgt;
            2'b11:   next_pc = jr_tgt;
            default: next_pc = pc_plus4;
        endcase
        if (irq_take) begin
            next_pc = IRQ_VECTOR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            if_id_q <= '0;
        end else begin
            if (!stall) begin
                pc <= next_pc;
            end
            if (flush || irq_take) begin
                if_id_q <= '0;
            end else if (!stall) begin
                if_id_q <= '{instr: imem_instr, pc_plus4: pc_plus4, valid: 1'b1};
            end
        end
    end

`ifdef FETCH_IRQ_EN
    // epc records the address that was about to be fetched when the interrupt was taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            epc <= 32'h0;
        end else if (irq_take) begin
            epc <= pc;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: reference model feeds an expectation queue, plus directed checks from the test plan.
module tb_pc_fetch_stage;

    localparam logic [31:0] IRQ_VEC = 32'h8000_0004;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] p4;
        logic        valid;
        logic [31:0] epc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [15:0] branch_offset = 16'h0;
    logic [25:0] jump_index = 26'h0;
    logic [31:0] jr_target = 32'h0;
    logic [31:0] imem_instr;
    logic [31:0] imem_addr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] w_addr;
    logic [31:0] unused_w_instr;
    logic [31:0] unused_w_p4;
    logic        unused_w_valid;
`ifdef FETCH_IRQ_EN
    logic        irq = 1'b0;
    logic [31:0] epc;
    logic [31:0] unused_w_epc;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t m = '0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_f(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0BAD_F00D;
    endfunction

    assign imem_instr = imem_f(imem_addr);

    pc_fetch_stage u_dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .pc_src(pc_src),
        .branch_offset(branch_offset), .jump_index(jump_index), .jr_target(jr_target),
        .imem_instr(imem_instr),
`ifdef FETCH_IRQ_EN
        .irq(irq), .epc(epc),
`endif
        .imem_addr(imem_addr), .if_id_instr(if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid)
    );

    pc_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .reset(reset), .stall(1'b0), .flush(1'b0), .pc_src(2'b00),
        .branch_offset(16'h0), .jump_index(26'h0), .jr_target(32'h0),
        .imem_instr(32'h0),
`ifdef FETCH_IRQ_EN
        .irq(1'b0), .epc(unused_w_epc),
`endif
        .imem_addr(w_addr), .if_id_instr(unused_w_instr),
        .if_id_pc_plus4(unused_w_p4), .if_id_valid(unused_w_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the post-edge state, then compare after the edge.
    task automatic step(input logic r, input logic s, input logic f, input logic [1:0] src,
                        input logic [15:0] bo, input logic [25:0] ji, input logic [31:0] jt);
        exp_t e;
        exp_t g;
        logic irq_now;
        reset = r; stall = s; flush = f; pc_src = src;
        branch_offset = bo; jump_index = ji; jr_target = jt;
        #1;
        irq_now = 1'b0;
`ifdef FETCH_IRQ_EN
        irq_now = irq && !s;
`endif
        e = m;
        if (r) begin
            e = '0;
            e.pc = 32'h0;
        end else begin
            if (!s) begin
                if (irq_now) begin
                    e.pc  = IRQ_VEC;
                    e.epc = m.pc;
                end else begin
                    case (src)
                        2'b00: e.pc = m.pc + 32'd4;
                        2'b01: e.pc = m.p4 + 32'($signed(bo)) * 32'd4;
                        2'b10: e.pc = (m.p4 & 32'hF000_0000) | ({6'b0, ji} << 2);
                        default: e.pc = jt & 32'hFFFF_FFFC;
                    endcase
                end
            end
            if (f || irq_now) begin
                e.instr = 32'h0; e.p4 = 32'h0; e.valid = 1'b0;
            end else if (!s) begin
                e.instr = imem_f(m.pc); e.p4 = m.pc + 32'd4; e.valid = 1'b1;
            end
        end
        exp_q.push_back(e);
        m = e;
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        check("m_pc", imem_addr, g.pc);
        check("m_instr", if_id_instr, g.instr);
        check("m_p4", if_id_pc_plus4, g.p4);
        check("m_valid", {31'b0, if_id_valid}, {31'b0, g.valid});
`ifdef FETCH_IRQ_EN
        check("m_epc", epc, g.epc);
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 26'h0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(1'b1, 1'b0, 1'b0, 2'b00, 16'h0, 26'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 2'b00, 16'h0, 26'h0, 32'h0);
        check("rst_pc", imem_addr, 32'h0);
        check("rst_instr", if_id_instr, 32'h0);
        check("rst_p4", if_id_pc_plus4, 32'h0);
        check("rst_valid", {31'b0, if_id_valid}, 32'h0);
        check("wrap_0", w_addr, 32'hFFFF_FFF8);

        run(1);
        check("seq_pc1", imem_addr, 32'h4);
        check("seq_p4_1", if_id_pc_plus4, 32'h4);
        check("seq_valid", {31'b0, if_id_valid}, 32'h1);
        check("wrap_1", w_addr, 32'hFFFF_FFFC);
        run(1);
        check("seq_pc2", imem_addr, 32'h8);
        check("seq_p4_2", if_id_pc_plus4, 32'h8);
        check("wrap_2", w_addr, 32'h0000_0000);
        run(1);
        check("seq_p4_3", if_id_pc_plus4, 32'hC);

        step(1'b0, 1'b0, 1'b1, 2'b01, 16'hFFFF, 26'h0, 32'h0);
        check("br_neg_pc", imem_addr, 32'h8);
        check("br_flush_valid", {31'b0, if_id_valid}, 32'h0);
        run(1);
        check("refetch_p4", if_id_pc_plus4, 32'hC);
        check("refetch_instr", if_id_instr, imem_f(32'h8));

        step(1'b0, 1'b0, 1'b0, 2'b10, 16'h0, 26'h3, 32'h0);
        check("jmp_pc", imem_addr, 32'hC);
        step(1'b0, 1'b0, 1'b0, 2'b11, 16'h0, 26'h0, 32'h0000_000B);
        check("jr_pc", imem_addr, 32'h8);

        run(2);
        check("pre_stall_pc", imem_addr, 32'h10);
        step(1'b0, 1'b1, 1'b0, 2'b01, 16'h5, 26'h0, 32'h0);
        check("stall1_pc", imem_addr, 32'h10);
        check("stall1_p4", if_id_pc_plus4, 32'h10);
        check("stall1_instr", if_id_instr, imem_f(32'hC));
        step(1'b0, 1'b1, 1'b1, 2'b01, 16'h5, 26'h0, 32'h0);
        check("stflush_pc", imem_addr, 32'h10);
        check("stflush_instr", if_id_instr, 32'h0);
        check("stflush_valid", {31'b0, if_id_valid}, 32'h0);
        step(1'b0, 1'b1, 1'b0, 2'b01, 16'h5, 26'h0, 32'h0);
        check("stall3_pc", imem_addr, 32'h10);
        run(1);
        check("unstall_pc", imem_addr, 32'h14);
        check("unstall_instr", if_id_instr, imem_f(32'h10));

        step(1'b0, 1'b0, 1'b0, 2'b01, 16'h0002, 26'h0, 32'h0);
        check("br_pos_pc", imem_addr, 32'h1C);

        step(1'b1, 1'b0, 1'b0, 2'b10, 16'h0, 26'h100, 32'h0);
        check("midrst_pc", imem_addr, 32'h0);
        check("midrst_valid", {31'b0, if_id_valid}, 32'h0);
        run(1);
        check("postrst_pc", imem_addr, 32'h4);

        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                 16'($urandom()), 26'($urandom()), $urandom());
        end

`ifdef FETCH_IRQ_EN
        step(1'b1, 1'b0, 1'b0, 2'b00, 16'h0, 26'h0, 32'h0);
        run(8);
        check("irq_pre_pc", imem_addr, 32'h20);
        irq = 1'b1;
        step(1'b0, 1'b0, 1'b0, 2'b10, 16'h0, 26'h3, 32'h0);
        check("irq_pc", imem_addr, 32'h8000_0004);
        check("irq_epc", epc, 32'h20);
        check("irq_valid", {31'b0, if_id_valid}, 32'h0);
        irq = 1'b0;
        run(1);
        check("irq_next_pc", imem_addr, 32'h8000_0008);
        irq = 1'b1;
        step(1'b0, 1'b1, 1'b0, 2'b10, 16'h0, 26'h3, 32'h0);
        check("irq_stall_pc", imem_addr, 32'h8000_0008);
        check("irq_stall_epc", epc, 32'h20);
        check("irq_stall_valid", {31'b0, if_id_valid}, 32'h1);
        irq = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the combinational instruction memory. It holds the program counter, drives the memory address, and computes the next PC from PC+4, branch, jump and jr sources. It also captures the returned instruction into an IF/ID pipeline register, with stall and flush control. This prepares the single-cycle datapath for the pipelined CPU.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
IRQ_VECTOR, 32'h80000004, interrupt entry address. Used only when FETCH_IRQ_EN is defined.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  hazard stall: hold the PC and the IF/ID register.
flush  input  1  kill the IF/ID contents (insert a bubble).
pc_src  input  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jr.
branch_offset  input  16  branch immediate in words, signed.
jump_index  input  26  J-type target index.
jr_target  input  32  register value for jr.
imem_instr  input  32  instruction returned by the instruction memory.
imem_addr  output  32  byte address to the instruction memory (equals the PC).
if_id_instr  output  32  registered instruction.
if_id_pc_plus4  output  32  registered PC+4 of the fetched instruction.
if_id_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Single clock domain. All state updates on the rising edge of clk.
- Reset values: pc = RESET_PC; if_id_instr = 0 (nop); if_id_pc_plus4 = 0; if_id_valid = 0.
- imem_addr = pc, combinational. No other logic sits between the PC and the memory.
- Instruction memory is combinational, so the instruction is registered into IF/ID on the same edge that advances the PC. Fetch-to-IF/ID latency is 1 cycle.
- pc_plus4 = pc + 4, modulo 2^32. 0xFFFFFFFC wraps to 0x00000000.
- Branch, jump and jr targets are resolved in ID, so all three are relative to if_id_pc_plus4:
  - branch_tgt = if_id_pc_plus4 + (sign_extend(branch_offset) << 2), modulo 2^32.
  - jump_tgt = {if_id_pc_plus4[31:28], jump_index, 2'b00}.
  - jr_tgt = jr_target. Bits [1:0] are forced to 00.
- Next-PC priority, highest first:
  1. reset
  2. stall: pc held, pc_src ignored
  3. pc_src != 00: pc <= selected target
  4. otherwise pc <= pc_plus4
- IF/ID update priority, highest first:
  1. reset
  2. flush: instr = 0, valid = 0, pc_plus4 = 0 (flush wins over stall)
  3. stall: hold all fields
  4. otherwise load imem_instr, pc_plus4, and valid = 1
- Redirect (pc_src != 00) while not stalled does not clear IF/ID by itself. The hazard unit asserts flush in the same cycle to kill the wrong-path instruction.
- stall + flush in the same cycle: PC held and IF/ID cleared. The same instruction is refetched next cycle.
- Reset asserted mid-stream discards any pending redirect. The first fetch after release is from RESET_PC.
- There is no internal state machine beyond the PC and IF/ID registers. Stall may be held any number of cycles with no loss of state.

Optional Feature:
FETCH_IRQ_EN.
- Defined:
  - Adds port irq (input, 1) and epc (output, 32, reset 0).
  - When irq = 1 and stall = 0, on that edge: pc <= IRQ_VECTOR, epc <= pc (the unfetched instruction's address), and IF/ID is bubbled (valid = 0).
  - irq has priority over pc_src; a redirect in that cycle is lost.
  - irq is ignored while stall = 1.
- Undefined: the ports are absent and behaviour is exactly as specified above.

Test Plan:
- Reset held 2 cycles, then released with pc_src = 00 and no stall -> imem_addr = 0x0, 0x4, 0x8 on successive cycles. if_id_pc_plus4 lags by one cycle (0x4, 0x8), and if_id_valid goes 0 -> 1.
- if_id_pc_plus4 = 0xC, pc_src = 01, branch_offset = 0xFFFF, flush = 1 -> next pc = 0x8, if_id_valid = 0. The following cycle refetches 0x8.
- if_id_pc_plus4 = 0x8, pc_src = 10, jump_index = 0x3 -> next pc = 0xC. Then pc_src = 11, jr_target = 0x0000000B -> pc = 0x8 (low bits forced to 00).
- stall held 3 cycles with pc = 0x10 and pc_src = 01 -> pc stays 0x10 and IF/ID is unchanged. Add flush in the 2nd cycle -> if_id_instr = 0, if_id_valid = 0, pc still 0x10.
- RESET_PC = 0xFFFFFFF8, run 3 cycles -> imem_addr = 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- FETCH_IRQ_EN defined, pc = 0x20, irq = 1 together with pc_src = 10 -> pc = 0x80000004, epc = 0x20, if_id_valid = 0. Repeat with stall = 1 -> no effect.
